mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
- Parametrised modulo up/down counter: the general-purpose successor to the fixed 4-bit free-running counter.
- Used for the multi-cycle datapath step counter, timers and test-bench stimulus sequencing.
- Adds the following, which the 4-bit counter lacks:
  - programmable width and modulus
  - count direction
  - enable
  - synchronous clear and load
  - wrap or saturate mode
  - boundary event flags

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32.
MAX, 15, terminal value; count range is 0..MAX; requires 1 <= MAX <= 2^WIDTH-1.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset; reset=0 clears all state immediately.
clear  in  1  synchronous clear to 0; highest synchronous priority.
load  in  1  synchronous load of load_val.
load_val  in  WIDTH  value to load.
en  in  1  count enable.
up  in  1  direction: 1 = increment, 0 = decrement.
sat  in  1  mode: 1 = saturate at boundary, 0 = wrap modulo MAX+1.
count  out  WIDTH  current count (registered).
at_max  out  1  combinational: count == MAX.
at_zero  out  1  combinational: count == 0.
wrap  out  1  registered one-cycle pulse: the previous edge crossed or hit a boundary while counting.

Behaviour:
- Reset (reset=0, asynchronous assert):
  - count=0, wrap=0, so at_zero=1 and at_max=0.
  - Deassertion takes effect at the next rising clk edge.
- Synchronous priority per edge: clear > load > en.
  - clear=1: count<=0, wrap<=0.
  - load=1 (clear=0): count<=min(load_val, MAX), i.e. values above MAX clamp to MAX; wrap<=0.
  - en=1 (clear=0, load=0), up=1:
    - count<MAX: count<=count+1; wrap<=0.
    - count==MAX, sat=0: count<=0; wrap<=1.
    - count==MAX, sat=1: count holds MAX; wrap<=1.
  - en=1 (clear=0, load=0), up=0:
    - count>0: count<=count-1; wrap<=0.
    - count==0, sat=0: count<=MAX; wrap<=1.
    - count==0, sat=1: count holds 0; wrap<=1.
  - en=0 with clear=0 and load=0: count holds; wrap<=0.
- wrap is never high on two consecutive cycles unless the boundary event repeats. Example: saturated and still enabled toward the boundary asserts wrap every cycle (level, by design).
- Latency: count reflects an operation one edge after it is sampled. at_max and at_zero follow count combinationally with zero added latency.
- Arithmetic:
  - Internal compare and increment are done in WIDTH+1 bits, so MAX = 2^WIDTH-1 wraps correctly with no truncation artefacts.
  - No count outside 0..MAX is ever reachable.
- Direction or mode may change on any cycle; they take effect on that edge with no pipeline state.
- Reset asserted mid-count: immediate return to reset values regardless of clk. There is no partial-update state.

Optional Feature:
- Macro: MOD_COUNTER_OVF_STICKY_EN.
- Defined:
  - Adds output ovf (1 bit, registered).
  - ovf is set on any edge where wrap is set.
  - ovf stays set until clear=1 or reset=0.
  - load does not clear ovf.
  - ovf resets to 0.
- Undefined: the ovf port and its register are absent; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=4, MAX=9.
1. Reset and count:
   - Stimulus: hold reset=0 for 2 cycles, release; en=1, up=1, sat=0 for 12 edges.
   - Response: count 1..9,0,1,2; wrap=1 only in the cycle count shows 0; at_max=1 while count=9.
2. Down wrap:
   - Stimulus: from count=0, en=1, up=0, sat=0 for 3 edges.
   - Response: count 9,8,7; wrap=1 in the cycle count=9 only.
3. Saturation:
   - Stimulus: load load_val=8, then en=1, up=1, sat=1 for 4 edges.
   - Response: count 9,9,9,9; wrap=1 on the last three cycles.
   - Then up=0, sat=1 from count=0: count holds 0 and wrap=1.
4. Priority and clamp:
   - Stimulus: clear=1, load=1, en=1 on the same edge.
   - Response: count=0.
   - Then load=1, load_val=14: count=9 (clamped); wrap=0.
5. Asynchronous reset mid-operation:
   - Stimulus: count=6, drive reset=0 between clock edges.
   - Response: count=0 and wrap=0 before the next edge.
   - Release reset with en=1: count=1 after the first edge following release.
6. MOD_COUNTER_OVF_STICKY_EN defined:
   - Stimulus: count up through 9->0.
   - Response: ovf=1 and stays 1 across load of 3.
   - Then clear=1: ovf=0.
   - Macro undefined: the bench checks that ovf is absent.

Source files
------------

// File: rtl/mod_counter_if.sv
// mod_counter_if: control and status bundle for mod_counter.
//   master: drives clear, load, load_val, en, up, sat; observes count and flags
//   slave : the counter itself
//   Signals:
//     clear        sync clear to 0 (highest priority)
//     load         sync load of load_val (clamped to MAX)
//     load_val     load value, WIDTH bits
//     en, up, sat  count enable, direction (1=up), saturate mode (1=saturate)
//     count        registered count
//     at_max       count == MAX (combinational)
//     at_zero      count == 0   (combinational)
//     wrap         registered one-cycle boundary pulse
//     ovf          sticky overflow, only with MOD_COUNTER_OVF_STICKY_EN
interface mod_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic             sat;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_zero;
    logic             wrap;
`ifdef MOD_COUNTER_OVF_STICKY_EN
    logic             ovf;
`endif

    modport master (
        output clear, load, load_val, en, up, sat,
        input  count, at_max, at_zero, wrap
`ifdef MOD_COUNTER_OVF_STICKY_EN
        , ovf
`endif
    );

    modport slave (
        input  clear, load, load_val, en, up, sat,
        output count, at_max, at_zero, wrap
`ifdef MOD_COUNTER_OVF_STICKY_EN
        , ovf
`endif
    );
endinterface

// File: rtl/mod_counter.sv
// mod_counter: parametrised modulo up/down counter, range 0..MAX.
//   clk   : clock, all state changes on rising edge
//   reset : asynchronous active-low reset
//   bus   : mod_counter_if.slave (controls in, count/flags out)
// Synchronous priority per edge: clear > load > en.
// Optional feature macro: MOD_COUNTER_OVF_STICKY_EN adds sticky bus.ovf,
// set by any wrap event, cleared only by clear or reset.
module mod_counter #(
    parameter int unsigned     WIDTH = 4,
    parameter longint unsigned MAX   = 15
) (
    input  logic          clk,
    input  logic          reset,
    mod_counter_if.slave  bus
);
    // Compare/increment in WIDTH+1 bits so MAX = 2^WIDTH-1 carries cleanly.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_nxt;
    logic             wrap_q, wrap_nxt;
    logic [WIDTH:0]   cnt_ext;
    logic             hit_max, hit_zero;

    assign cnt_ext  = {1'b0, count_q};
    assign hit_max  = (cnt_ext == MAX_EXT);
    assign hit_zero = (count_q == '0);

    always_comb begin
        count_nxt = count_q;
        wrap_nxt  = 1'b0;
        if (bus.clear) begin
            count_nxt = '0;
        end else if (bus.load) begin
            // out-of-range loads clamp so count never leaves 0..MAX
            count_nxt = ({1'b0, bus.load_val} > MAX_EXT) ? MAX_W : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (hit_max) begin
                    wrap_nxt  = 1'b1;
                    count_nxt = bus.sat ? count_q : '0;
                end else begin
                    count_nxt = WIDTH'(cnt_ext + (WIDTH+1)'(1));
                end
            end else begin
                if (hit_zero) begin
                    wrap_nxt  = 1'b1;
                    count_nxt = bus.sat ? count_q : MAX_W;
                end else begin
                    count_nxt = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    assign bus.count   = count_q;
    assign bus.wrap    = wrap_q;
    assign bus.at_max  = hit_max;
    assign bus.at_zero = hit_zero;

`ifdef MOD_COUNTER_OVF_STICKY_EN
    logic ovf_q;

    // load deliberately leaves ovf alone; only clear or reset drop it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         ovf_q <= 1'b0;
        else if (bus.clear) ovf_q <= 1'b0;
        else if (wrap_nxt)  ovf_q <= 1'b1;
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed, table-driven bench for mod_counter (WIDTH=4, MAX=9).
// Inputs change on the falling edge; outputs are sampled #1 after the rising edge.
module tb_mod_counter;
    localparam int W = 4;

    typedef struct {
        logic         clear;
        logic         load;
        logic [W-1:0] load_val;
        logic         en;
        logic         up;
        logic         sat;
        logic [W-1:0] exp_count;
        logic         exp_wrap;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t tbl[$];

    mod_counter_if #(.WIDTH(W)) bus ();

    mod_counter #(.WIDTH(W), .MAX(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic c, input logic l, input int lv, input logic e,
                                input logic u, input logic s, input int cnt, input logic w);
        vec_t v;
        v.clear = c; v.load = l; v.load_val = W'(lv); v.en = e; v.up = u; v.sat = s;
        v.exp_count = W'(cnt); v.exp_wrap = w;
        tbl.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        bus.clear = v.clear; bus.load = v.load; bus.load_val = v.load_val;
        bus.en = v.en; bus.up = v.up; bus.sat = v.sat;
    endtask

    task automatic check_state(input string tag, input int cnt, input logic w);
        check({tag, ".count"},   bus.count, cnt);
        check({tag, ".wrap"},    bus.wrap, w);
        check({tag, ".at_max"},  bus.at_max, (cnt == 9));
        check({tag, ".at_zero"}, bus.at_zero, (cnt == 0));
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check_state(tag, v.exp_count, v.exp_wrap);
    endtask

    initial begin
        vec_t v;
        // 1: count up with wrap at 9->0
        for (int i = 1; i <= 12; i++) add(0, 0, 0, 1, 1, 0, i % 10, (i == 10));
        add(1, 0, 0, 0, 0, 0, 0, 0);                  // clear
        // 2: down wrap from 0
        add(0, 0, 0, 1, 0, 0, 9, 1);
        add(0, 0, 0, 1, 0, 0, 8, 0);
        add(0, 0, 0, 1, 0, 0, 7, 0);
        // 3: saturation up, then down at 0
        add(0, 1, 8, 0, 0, 0, 8, 0);
        add(0, 0, 0, 1, 1, 1, 9, 0);
        add(0, 0, 0, 1, 1, 1, 9, 1);
        add(0, 0, 0, 1, 1, 1, 9, 1);
        add(0, 0, 0, 1, 1, 1, 9, 1);
        add(0, 0, 0, 0, 1, 1, 9, 0);                  // en=0: hold, wrap drops
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 1, 0, 1);
        // 4: priority and clamp
        add(0, 1, 5, 0, 0, 0, 5, 0);
        add(1, 1, 5, 1, 1, 0, 0, 0);                  // clear beats load and en
        add(0, 1, 14, 1, 1, 0, 9, 0);                 // clamp, load beats en
        add(0, 1, 15, 0, 0, 0, 9, 0);
        add(0, 1, 3, 1, 0, 0, 3, 0);
        add(0, 0, 0, 0, 0, 0, 3, 0);
        add(0, 0, 0, 1, 0, 0, 2, 0);
        add(0, 0, 0, 1, 1, 0, 3, 0);                  // direction change

        drive('{0, 0, 0, 0, 0, 0, 0, 0});
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 0);
`ifdef MOD_COUNTER_OVF_STICKY_EN
        check("reset.ovf", bus.ovf, 0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // 5: async reset mid-operation
        add(0, 1, 6, 0, 0, 0, 6, 0);
        step(tbl[tbl.size()-1], "t5.load6");
        @(negedge clk);
        drive('{0, 0, 0, 1, 1, 0, 0, 0});
        #2 reset = 1'b0;
        #1;
        check_state("t5.async", 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_state("t5.release", 1, 0);

`ifdef MOD_COUNTER_OVF_STICKY_EN
        // 6: sticky overflow
        v = '{0, 1, 4'd9, 0, 0, 0, 4'd9, 0};
        step(v, "t6.load9");
        check("t6.ovf0", bus.ovf, 0);
        v = '{0, 0, 4'd0, 1, 1, 0, 4'd0, 1};
        step(v, "t6.wrap");
        check("t6.ovf_set", bus.ovf, 1);
        v = '{0, 1, 4'd3, 0, 0, 0, 4'd3, 0};
        step(v, "t6.load3");
        check("t6.ovf_load", bus.ovf, 1);
        v = '{0, 0, 4'd0, 1, 1, 0, 4'd4, 0};
        step(v, "t6.count");
        check("t6.ovf_hold", bus.ovf, 1);
        v = '{1, 0, 4'd0, 0, 0, 0, 4'd0, 0};
        step(v, "t6.clear");
        check("t6.ovf_clr", bus.ovf, 0);
`else
        // feature absent: bus has no ovf; plain hold keeps count
        v = '{0, 0, 4'd0, 0, 0, 0, 4'd1, 0};
        step(v, "t6.nofeat");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
